contrast_brightness_pipe: RTL and testbench

//  Streaming per-channel contrast/brightness stage: out = clamp((pix*gain)>>GAIN_FRAC + offset).

---
 rtl/cb_pkg.sv | 19 +
 rtl/cb_channel.sv | 76 +++++++
 rtl/contrast_brightness_pipe.sv | 136 +++++++++++++
 tb/tb_contrast_brightness_pipe.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cb_pkg.sv
// Shared constants and width rules for the contrast/brightness pipeline.
//   CB_GAIN_FRAC : fractional bits of the per-channel gain
//   CB_DEF_GAIN  : gain loaded at reset (x1.25 with 2 fractional bits)
//   CB_DEF_OFF   : signed offset loaded at reset
//   cbSumWidth() : width of the signed shift+offset sum, including guard bits
package cb_pkg;

  localparam int unsigned CB_GAIN_FRAC = 2;
  localparam int unsigned CB_DEF_GAIN  = 5;
  localparam int          CB_DEF_OFF   = 32;

  // Wider of the scaled product and the offset, plus two guard bits so the
  // signed sum can neither wrap positive nor negative.
  function automatic int unsigned cbSumWidth(input int unsigned sclW,
                                             input int unsigned offW);
    return ((sclW > offW) ? sclW : offW) + 2;
  endfunction

endpackage

// File: rtl/cb_channel.sv
// One colour channel of the contrast/brightness pipeline.
//   S1: prod = pix * gain (unsigned), offset carried alongside
//   S2: sum  = (prod >> GAIN_FRAC) + sign-extended offset
//   S3: clamp to [0, 2^CH_W-1], clip flag set when either bound is hit
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   adv          : pipeline advance; all stages hold when low
//   pix/gain/off : channel inputs captured into S1 on adv
//   outPix/clip  : S3 result and its clip flag
module cb_channel
  import cb_pkg::*;
#(
  parameter int unsigned CH_W      = 8,
  parameter int unsigned GAIN_W    = 8,
  parameter int unsigned GAIN_FRAC = CB_GAIN_FRAC,
  parameter int unsigned OFF_W     = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              adv,
  input  logic [CH_W-1:0]   pix,
  input  logic [GAIN_W-1:0] gain,
  input  logic [OFF_W-1:0]  off,
  output logic [CH_W-1:0]   outPix,
  output logic              clip
);

  localparam int unsigned PROD_W = CH_W + GAIN_W;
  localparam int unsigned SCL_W  = PROD_W - GAIN_FRAC;
  localparam int unsigned SUM_W  = cbSumWidth(SCL_W, OFF_W);
  localparam logic signed [SUM_W-1:0] PIX_MAX = SUM_W'((1 << CH_W) - 1);

  logic [PROD_W-1:0]       prodQ;
  logic [OFF_W-1:0]        offQ;
  logic signed [SUM_W-1:0] sumQ;
  logic signed [SUM_W-1:0] sclExt;
  logic signed [SUM_W-1:0] offExt;
  logic signed [SUM_W-1:0] sumD;
  logic [CH_W-1:0]         clampD;
  logic                    clipD;

  always_comb begin
    sclExt = SUM_W'(prodQ >> GAIN_FRAC);
    offExt = SUM_W'($signed(offQ));
    sumD   = sclExt + offExt;
  end

  always_comb begin
    clampD = sumQ[CH_W-1:0];
    clipD  = 1'b0;
    if (sumQ[SUM_W-1]) begin
      clampD = '0;
      clipD  = 1'b1;
    end else if (sumQ > PIX_MAX) begin
      clampD = '1;
      clipD  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prodQ  <= '0;
      offQ   <= '0;
      sumQ   <= '0;
      outPix <= '0;
      clip   <= 1'b0;
    end else if (adv) begin
      prodQ  <= PROD_W'(pix) * PROD_W'(gain);
      offQ   <= off;
      sumQ   <= sumD;
      outPix <= clampD;
      clip   <= clipD;
    end
  end

endmodule

// File: rtl/contrast_brightness_pipe.sv
// Streaming per-channel contrast/brightness stage:
//   out = clamp((pix*gain) >> GAIN_FRAC + offset), 3-cycle latency, 1 beat/clk.
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset
//   in_valid/in_ready    : input handshake (in_ready = global advance)
//   in_sof, in_pixel     : frame-start flag and packed pixel (ch0 in MSBs)
//   out_valid/out_ready  : output handshake
//   out_sof, out_pixel   : delayed frame-start flag and adjusted pixel
//   cfg_we/gain/off      : write of the pending configuration
//   clip_count           : clipped beats in the current output frame (saturating)
module contrast_brightness_pipe
  import cb_pkg::*;
#(
  parameter int unsigned CH_W      = 8,
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned GAIN_W    = 8,
  parameter int unsigned GAIN_FRAC = CB_GAIN_FRAC,
  parameter int unsigned OFF_W     = 9
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sof,
  input  logic [NUM_CH*CH_W-1:0]   in_pixel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sof,
  output logic [NUM_CH*CH_W-1:0]   out_pixel,
  input  logic                     cfg_we,
  input  logic [NUM_CH*GAIN_W-1:0] cfg_gain,
  input  logic [NUM_CH*OFF_W-1:0]  cfg_off,
  output logic [15:0]              clip_count
);

  localparam logic [NUM_CH*GAIN_W-1:0] DEF_GAIN_BUS = {NUM_CH{GAIN_W'(CB_DEF_GAIN)}};
  localparam logic [NUM_CH*OFF_W-1:0]  DEF_OFF_BUS  = {NUM_CH{OFF_W'(CB_DEF_OFF)}};

  logic adv;
  logic accept;
  logic s1Valid, s2Valid, s3Valid;
  logic s1Sof, s2Sof, s3Sof;

  logic [NUM_CH*GAIN_W-1:0] pendGain, actGain, useGain;
  logic [NUM_CH*OFF_W-1:0]  pendOff, actOff, useOff;
  logic [NUM_CH-1:0]        clipVec;
  logic                     clipBeat;

  assign adv      = !s3Valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  // A frame-start beat reads the pending registers directly, so it sees the
  // new frame's settings in the same cycle they are promoted to active.
  always_comb begin
    useGain = actGain;
    useOff  = actOff;
    if (in_sof) begin
      useGain = pendGain;
      useOff  = pendOff;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pendGain <= DEF_GAIN_BUS;
      pendOff  <= DEF_OFF_BUS;
      actGain  <= DEF_GAIN_BUS;
      actOff   <= DEF_OFF_BUS;
    end else begin
      if (accept && in_sof) begin
        actGain <= pendGain;
        actOff  <= pendOff;
      end
      if (cfg_we) begin
        pendGain <= cfg_gain;
        pendOff  <= cfg_off;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1Valid <= 1'b0;
      s2Valid <= 1'b0;
      s3Valid <= 1'b0;
      s1Sof   <= 1'b0;
      s2Sof   <= 1'b0;
      s3Sof   <= 1'b0;
    end else if (adv) begin
      s1Valid <= accept;
      s2Valid <= s1Valid;
      s3Valid <= s2Valid;
      s1Sof   <= accept && in_sof;
      s2Sof   <= s1Sof;
      s3Sof   <= s2Sof;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : gCh
    localparam int unsigned SLOT = NUM_CH - 1 - i;

    cb_channel #(
      .CH_W      (CH_W),
      .GAIN_W    (GAIN_W),
      .GAIN_FRAC (GAIN_FRAC),
      .OFF_W     (OFF_W)
    ) uChannel (
      .clk     (clk),
      .reset_n (reset_n),
      .adv     (adv),
      .pix     (in_pixel[SLOT*CH_W +: CH_W]),
      .gain    (useGain[SLOT*GAIN_W +: GAIN_W]),
      .off     (useOff[SLOT*OFF_W +: OFF_W]),
      .outPix  (out_pixel[SLOT*CH_W +: CH_W]),
      .clip    (clipVec[i])
    );
  end

  assign out_valid = s3Valid;
  assign out_sof   = s3Sof;
  assign clipBeat  = |clipVec;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clip_count <= '0;
    end else if (out_valid && out_ready) begin
      if (out_sof) begin
        clip_count <= clipBeat ? 16'd1 : 16'd0;
      end else if (clipBeat && (clip_count != '1)) begin
        clip_count <= clip_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_contrast_brightness_pipe.sv
module tb_contrast_brightness_pipe;

  localparam logic [23:0] DEF_G = {8'd5, 8'd5, 8'd5};
  localparam logic [26:0] DEF_O = {9'h020, 9'h020, 9'h020};

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sof = 1'b0;
  logic [23:0] in_pixel = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sof;
  logic [23:0] out_pixel;
  logic        cfg_we = 1'b0;
  logic [23:0] cfg_gain = '0;
  logic [26:0] cfg_off = '0;
  logic [15:0] clip_count;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  bit freeFlow = 1'b1;
  bit bpMode = 1'b0;

  typedef struct {
    logic [23:0] pix;
    bit          sof;
    bit          clip;
    int          acc;
  } exp_t;

  exp_t        q[$];
  logic [23:0] mPendG = DEF_G, mActG = DEF_G;
  logic [26:0] mPendO = DEF_O, mActO = DEF_O;
  int          mClip = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  always @(posedge clk) begin
    #1;
    out_ready = bpMode ? ($urandom_range(0, 9) < 3) : 1'b1;
  end

  contrast_brightness_pipe #(
    .CH_W(8), .NUM_CH(3), .GAIN_W(8), .GAIN_FRAC(2), .OFF_W(9)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof), .out_pixel(out_pixel),
    .cfg_we(cfg_we), .cfg_gain(cfg_gain), .cfg_off(cfg_off), .clip_count(clip_count)
  );

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: plain integers, truncating divide by 4 for the 2 fraction bits.
  function automatic int chAdj(input int pix, input int gain, input int off, output bit clip);
    int s;
    s = (pix * gain) / 4 + off;
    clip = 1'b0;
    if (s < 0) begin
      s = 0;
      clip = 1'b1;
    end else if (s > 255) begin
      s = 255;
      clip = 1'b1;
    end
    return s;
  endfunction

  function automatic logic [23:0] pixAdj(input logic [23:0] p, input logic [23:0] g,
                                         input logic [26:0] o, output bit clip);
    logic [23:0] r;
    bit c;
    int v;
    r = '0;
    clip = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v = chAdj(int'(p[(2-i)*8 +: 8]), int'(g[(2-i)*8 +: 8]),
                int'($signed(o[(2-i)*9 +: 9])), c);
      r[(2-i)*8 +: 8] = v[7:0];
      clip = clip | c;
    end
    return r;
  endfunction

  // Model and compare, sampled on the falling edge.
  logic [23:0] lastPix = '0;
  bit          lastSof = 1'b0;
  bit          lastStall = 1'b0;

  always @(negedge clk) begin : mon
    exp_t        e;
    bit          c;
    logic [23:0] g;
    logic [26:0] o;
    if (!reset_n) begin
      q.delete();
      mPendG = DEF_G; mActG = DEF_G;
      mPendO = DEF_O; mActO = DEF_O;
      mClip = 0;
      lastStall = 1'b0;
    end else begin
      check(clip_count == 16'(mClip), "clip_count", 32'(clip_count), 32'(mClip));
      check(in_ready == (!out_valid || out_ready), "in_ready", 32'(in_ready),
            32'(!out_valid || out_ready));
      if (lastStall && out_valid) begin
        check(out_pixel == lastPix && out_sof == lastSof, "stall_hold",
              {7'd0, out_sof, out_pixel}, {7'd0, lastSof, lastPix});
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check(1'b0, "unexpected_output", 32'(out_pixel), 32'hFFFFFFFF);
        end else begin
          e = q.pop_front();
          check(out_pixel == e.pix, "out_pixel", 32'(out_pixel), 32'(e.pix));
          check(out_sof == e.sof, "out_sof", 32'(out_sof), 32'(e.sof));
          if (freeFlow) check(cycle - e.acc == 3, "latency", cycle - e.acc, 3);
          if (e.sof) mClip = e.clip ? 1 : 0;
          else if (e.clip && mClip < 65535) mClip++;
        end
      end
      lastStall = out_valid && !out_ready;
      lastPix = out_pixel;
      lastSof = out_sof;
      if (in_valid && in_ready) begin
        g = in_sof ? mPendG : mActG;
        o = in_sof ? mPendO : mActO;
        e.pix = pixAdj(in_pixel, g, o, c);
        e.sof = in_sof;
        e.clip = c;
        e.acc = cycle;
        q.push_back(e);
        if (in_sof) begin
          mActG = mPendG;
          mActO = mPendO;
        end
      end
      if (cfg_we) begin
        mPendG = cfg_gain;
        mPendO = cfg_off;
      end
    end
  end

  task automatic sendBeat(input bit sof, input logic [23:0] pix, input bit we,
                          input logic [23:0] g, input logic [26:0] o);
    bit acc;
    int n;
    in_valid = 1'b1; in_sof = sof; in_pixel = pix;
    cfg_we = we; cfg_gain = g; cfg_off = o;
    n = 0;
    acc = 1'b0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 300);
    if (!acc) check(1'b0, "accept_timeout", 0, 1);
    in_valid = 1'b0; in_sof = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic cfgWrite(input logic [23:0] g, input logic [26:0] o);
    cfg_we = 1'b1; cfg_gain = g; cfg_off = o;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic waitOut(input logic [23:0] expPix, input string name);
    int n;
    bit hs;
    n = 0;
    hs = 1'b0;
    do begin
      @(negedge clk);
      hs = out_valid && out_ready;
      n++;
    end while (!hs && n < 20);
    check(hs, {name, "_timeout"}, 32'(hs), 1);
    if (hs) check(out_pixel == expPix, name, 32'(out_pixel), 32'(expPix));
    @(posedge clk);
    #1;
  endtask

  task automatic sendCheck(input bit sof, input logic [23:0] pix, input bit we,
                           input logic [23:0] g, input logic [26:0] o,
                           input logic [23:0] expPix, input string name);
    sendBeat(sof, pix, we, g, o);
    waitOut(expPix, name);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit c;
    bit sawV;
    int n;
    logic [23:0] v;

    // Literal pins on the model itself.
    v = pixAdj(24'h804000, DEF_G, DEF_O, c);
    check(v == 24'hC07020 && !c, "model_default", 32'(v), 32'hC07020);
    v = pixAdj(24'h202020, {8'd4, 8'd8, 8'd2}, {9'h000, 9'h1F0, 9'h0FF}, c);
    check(v == 24'h2030FF && c, "model_indep", 32'(v), 32'h2030FF);
    v = pixAdj(24'h101010, {8'd4, 8'd4, 8'd4}, {9'h1C0, 9'h1C0, 9'h1C0}, c);
    check(v == 24'h000000 && c, "model_neg", 32'(v), 32'h0);

    repeat (2) @(negedge clk);
    check(out_valid == 1'b0 && out_sof == 1'b0, "reset_ctrl", {out_valid, out_sof}, 0);
    check(out_pixel == 24'h0, "reset_pixel", 32'(out_pixel), 0);
    check(clip_count == 16'h0, "reset_clip", 32'(clip_count), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1. Defaults
    sendCheck(1'b1, 24'h804000, 1'b0, '0, '0, 24'hC07020, "t1_default");
    check(clip_count == 16'd0, "t1_clip", 32'(clip_count), 0);

    // 2. Saturation both ends
    sendCheck(1'b0, 24'hFFFFFF, 1'b0, '0, '0, 24'hFFFFFF, "t2_high");
    check(clip_count == 16'd1, "t2_clip_high", 32'(clip_count), 1);
    cfgWrite({8'd4, 8'd4, 8'd4}, {9'h1C0, 9'h1C0, 9'h1C0});
    sendCheck(1'b1, 24'h101010, 1'b0, '0, '0, 24'h000000, "t2_low");
    check(clip_count == 16'd1, "t2_clip_restart", 32'(clip_count), 1);

    // 3. Frame-boundary shadowing
    cfgWrite(DEF_G, DEF_O);
    sendCheck(1'b1, 24'h101010, 1'b0, '0, '0, 24'h343434, "t3_frame_a");
    cfgWrite({8'd8, 8'd8, 8'd8}, DEF_O);
    sendCheck(1'b0, 24'h101010, 1'b0, '0, '0, 24'h343434, "t3_midframe_hold");
    sendCheck(1'b1, 24'h101010, 1'b0, '0, '0, 24'h404040, "t3_next_sof");
    sendCheck(1'b1, 24'h101010, 1'b1, {8'd4, 8'd4, 8'd4}, DEF_O, 24'h404040, "t3_sof_we");
    sendCheck(1'b0, 24'h101010, 1'b0, '0, '0, 24'h404040, "t3_sof_we_active");
    sendCheck(1'b1, 24'h101010, 1'b0, '0, '0, 24'h303030, "t3_one_frame_later");

    // 5. Channel independence
    cfgWrite({8'd4, 8'd8, 8'd2}, {9'h000, 9'h1F0, 9'h0FF});
    sendCheck(1'b1, 24'h202020, 1'b0, '0, '0, 24'h2030FF, "t5_indep");
    check(clip_count == 16'd1, "t5_clip", 32'(clip_count), 1);

    // 4. Back-pressure with random traffic
    freeFlow = 1'b0;
    bpMode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 9) < 3) begin
        @(posedge clk);
        #1;
      end
      sendBeat((i % 97) == 0, 24'($urandom), ($urandom_range(0, 19) == 0),
               24'($urandom), 27'($urandom));
    end
    n = 0;
    while (q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check(q.size() == 0, "t4_drain", q.size(), 0);
    bpMode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    freeFlow = 1'b1;

    // 6. Async reset with three beats in flight
    sendBeat(1'b0, 24'h111111, 1'b0, '0, '0);
    sendBeat(1'b0, 24'h222222, 1'b0, '0, '0);
    sendBeat(1'b0, 24'h333333, 1'b0, '0, '0);
    check(out_valid == 1'b1, "t6_inflight", 32'(out_valid), 1);
    reset_n = 1'b0;
    #1;
    check(out_valid == 1'b0, "t6_valid_drop", 32'(out_valid), 0);
    check(out_pixel == 24'h0, "t6_pixel_clear", 32'(out_pixel), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    sawV = 1'b0;
    repeat (8) begin
      @(negedge clk);
      sawV = sawV | out_valid;
    end
    check(!sawV, "t6_no_stale", 32'(sawV), 0);
    @(posedge clk);
    #1;
    sendCheck(1'b0, 24'h804000, 1'b0, '0, '0, 24'hC07020, "t6_cfg_default");
    check(clip_count == 16'd0, "t6_clip", 32'(clip_count), 0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
